// File: rtl/sonar_pkg.sv
// Shared types and constants for the sonar receive path.
package sonar_pkg;

  // Word width shared by spi_con, the ADC responder and the top level.
  localparam int unsigned ADC_DATA_WIDTH = 16;

  // SPI responder frame state.
  typedef enum logic [1:0] {
    StIdle,
    StShift,
    StDone
  } spi_resp_state_t;

endpackage

// File: rtl/edge_sync.sv
// Synchronizer with rise/fall pulse outputs.
// SYNC_STAGES flops bring sig_i into the clk_i domain; one compare flop after the
// last stage produces single-cycle rise/fall pulses. SYNC_STAGES = 0 compares the
// raw input directly, for sources already on clk_i.
module edge_sync #(
  parameter int unsigned SYNC_STAGES = 2,
  parameter logic        RESET_VAL   = 1'b0
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic sig_i,
  output logic rise_o,
  output logic fall_o
);

  logic sync_last;
  logic prev_q;

  if (SYNC_STAGES == 0) begin : g_direct
    assign sync_last = sig_i;
  end else begin : g_sync
    logic [SYNC_STAGES-1:0] sync_q;

    // Shift the input through the synchronizer chain.
    always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
        sync_q <= {SYNC_STAGES{RESET_VAL}};
      end else begin
        sync_q[0] <= sig_i;
        for (int i = 1; i < SYNC_STAGES; i++) begin
          sync_q[i] <= sync_q[i-1];
        end
      end
    end

    assign sync_last = sync_q[SYNC_STAGES-1];
  end

  // Remember the previous synchronized level for edge comparison.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      prev_q <= RESET_VAL;
    end else begin
      prev_q <= sync_last;
    end
  end

  assign rise_o = sync_last & ~prev_q;
  assign fall_o = ~sync_last & prev_q;

endmodule

// File: rtl/adc_spi_responder.sv
// SPI responder emulating the echo ADC behind spi_con.
// Words arrive through a one-entry holding register (valid/ready) and are shifted
// out MSB-first on chip_data_out while CS is low, advancing on each DCLK fall.
// Optional feature macro: ADC_SPI_RESP_UNDERRUN_EN -- when defined, a frame that
// starts with an empty holding register shifts UNDERRUN_WORD; otherwise it
// re-sends the last word loaded from the holding register.
module adc_spi_responder
  import sonar_pkg::*;
#(
  parameter int unsigned           DATA_WIDTH    = ADC_DATA_WIDTH,
  parameter int unsigned           SYNC_STAGES   = 2,
  parameter logic [DATA_WIDTH-1:0] UNDERRUN_WORD = DATA_WIDTH'(16'hDEAD)
) (
  input  logic                  clk_in,
  input  logic                  rst_in,
  input  logic [DATA_WIDTH-1:0] sample_in,
  input  logic                  sample_valid_in,
  output logic                  sample_ready_out,
  input  logic                  chip_clk_in,
  input  logic                  chip_sel_in,
  output logic                  chip_data_out,
  output logic                  frame_done_out,
  output logic                  frame_abort_out,
  output logic                  underrun_out
);

  // Counts DCLK rises up to DATA_WIDTH inclusive.
  localparam int unsigned     CntW    = $clog2(DATA_WIDTH) + 1;
  localparam logic [CntW-1:0] LastCnt = CntW'(DATA_WIDTH - 1);

  spi_resp_state_t       state_q;
  logic [DATA_WIDTH-1:0] shift_q;
  logic [DATA_WIDTH-1:0] hold_q;
  logic                  hold_full_q;
  logic [CntW-1:0]       cnt_q;
  logic                  data_q;
  logic                  done_q;
  logic                  abort_q;
  logic                  underrun_q;

  logic                  dclk_rise;
  logic                  dclk_fall;
  logic                  cs_rise;
  logic                  cs_fall;
  logic                  accept;
  logic                  frame_start;
  logic [DATA_WIDTH-1:0] underrun_src;
  logic [DATA_WIDTH-1:0] load_word;

  edge_sync #(
    .SYNC_STAGES (SYNC_STAGES),
    .RESET_VAL   (1'b0)
  ) u_dclk_sync (
    .clk_i  (clk_in),
    .rst_i  (rst_in),
    .sig_i  (chip_clk_in),
    .rise_o (dclk_rise),
    .fall_o (dclk_fall)
  );

  // CS idles high, so its synchronizer resets high to avoid a false fall.
  edge_sync #(
    .SYNC_STAGES (SYNC_STAGES),
    .RESET_VAL   (1'b1)
  ) u_cs_sync (
    .clk_i  (clk_in),
    .rst_i  (rst_in),
    .sig_i  (chip_sel_in),
    .rise_o (cs_rise),
    .fall_o (cs_fall)
  );

  assign accept      = sample_valid_in & ~hold_full_q;
  assign frame_start = cs_fall & (state_q == StIdle);

`ifdef ADC_SPI_RESP_UNDERRUN_EN
  assign underrun_src = UNDERRUN_WORD;
`else
  logic [DATA_WIDTH-1:0] last_word_q;
  logic                  unused_underrun_word;

  assign underrun_src         = last_word_q;
  assign unused_underrun_word = ^UNDERRUN_WORD;

  // Keep the most recent word taken from the holding register for re-send.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      last_word_q <= '0;
    end else if (frame_start && hold_full_q) begin
      last_word_q <= hold_q;
    end
  end
`endif

  assign load_word = hold_full_q ? hold_q : underrun_src;

  // Holding register: drained by a frame start, filled by a producer transfer.
  // A transfer in the same cycle as an underrun frame start fills it for the
  // following frame, since the load above already chose the underrun source.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      hold_q      <= '0;
      hold_full_q <= 1'b0;
    end else if (frame_start && hold_full_q) begin
      hold_full_q <= 1'b0;
    end else if (accept) begin
      hold_q      <= sample_in;
      hold_full_q <= 1'b1;
    end
  end

  // Frame FSM with registered serial data and status pulses.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state_q    <= StIdle;
      shift_q    <= '0;
      cnt_q      <= '0;
      data_q     <= 1'b0;
      done_q     <= 1'b0;
      abort_q    <= 1'b0;
      underrun_q <= 1'b0;
    end else begin
      done_q     <= 1'b0;
      abort_q    <= 1'b0;
      underrun_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          data_q <= 1'b0;
          if (cs_fall) begin
            state_q    <= StShift;
            shift_q    <= load_word;
            cnt_q      <= '0;
            data_q     <= load_word[DATA_WIDTH-1];
            underrun_q <= ~hold_full_q;
          end
        end
        StShift: begin
          if (cs_rise) begin
            // CS released before the last bit was sampled.
            state_q <= StIdle;
            abort_q <= 1'b1;
            data_q  <= 1'b0;
          end else if (dclk_rise) begin
            cnt_q <= cnt_q + 1'b1;
            if (cnt_q == LastCnt) begin
              state_q <= StDone;
              done_q  <= 1'b1;
              data_q  <= 1'b0;
            end
          end else if (dclk_fall) begin
            shift_q <= shift_q << 1;
            data_q  <= shift_q[DATA_WIDTH-2];
          end
        end
        StDone: begin
          data_q <= 1'b0;
          if (cs_rise) begin
            state_q <= StIdle;
          end
        end
        default: begin
          state_q <= StIdle;
          data_q  <= 1'b0;
        end
      endcase
    end
  end

  assign sample_ready_out = ~hold_full_q;
  assign chip_data_out    = data_q;
  assign frame_done_out   = done_q;
  assign frame_abort_out  = abort_q;
  assign underrun_out     = underrun_q;

endmodule

// File: tb/tb_adc_spi_responder.sv
// Randomized bench for adc_spi_responder: a direct-compare instance
// (SYNC_STAGES=0) and a synchronized instance (SYNC_STAGES=2) share one SPI
// controller model and producer, and are scored against a word-level model.
module tb_adc_spi_responder;
  import sonar_pkg::*;

  localparam int W = ADC_DATA_WIDTH;
  localparam logic [W-1:0] UNDER = 16'hDEAD;

  logic         clk = 1'b0;
  logic         rst;
  logic [W-1:0] sample;
  logic         valid;
  logic         dclk;
  logic         cs;

  logic ready0, data0, done0, abort0, under0;
  logic ready2, data2, done2, abort2, under2;

  always #5 clk = ~clk;

  adc_spi_responder #(
    .DATA_WIDTH  (W),
    .SYNC_STAGES (0)
  ) u_dut0 (
    .clk_in           (clk),
    .rst_in           (rst),
    .sample_in        (sample),
    .sample_valid_in  (valid),
    .sample_ready_out (ready0),
    .chip_clk_in      (dclk),
    .chip_sel_in      (cs),
    .chip_data_out    (data0),
    .frame_done_out   (done0),
    .frame_abort_out  (abort0),
    .underrun_out     (under0)
  );

  adc_spi_responder #(
    .DATA_WIDTH  (W),
    .SYNC_STAGES (2)
  ) u_dut2 (
    .clk_in           (clk),
    .rst_in           (rst),
    .sample_in        (sample),
    .sample_valid_in  (valid),
    .sample_ready_out (ready2),
    .chip_clk_in      (dclk),
    .chip_sel_in      (cs),
    .chip_data_out    (data2),
    .frame_done_out   (done2),
    .frame_abort_out  (abort2),
    .underrun_out     (under2)
  );

  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Pulse-cycle counters, sampled away from the active edge.
  int n_done0 = 0, n_abort0 = 0, n_under0 = 0;
  int n_done2 = 0, n_abort2 = 0, n_under2 = 0;

  always @(negedge clk) begin
    if (done0 === 1'b1)  n_done0++;
    if (abort0 === 1'b1) n_abort0++;
    if (under0 === 1'b1) n_under0++;
    if (done2 === 1'b1)  n_done2++;
    if (abort2 === 1'b1) n_abort2++;
    if (under2 === 1'b1) n_under2++;
  end

  // Word-level model: queue of accepted words and the last word sent from it.
  logic [W-1:0] hold_m[$];
  logic [W-1:0] last_word_m = '0;

  // Offer a word until both instances have taken it. Starts and ends at a negedge.
  task automatic push(input logic [W-1:0] w);
    bit a0 = 0;
    bit a2 = 0;
    sample = w;
    valid  = 1'b1;
    for (int n = 0; n < 200 && !(a0 && a2); n++) begin
      if (ready0) a0 = 1;
      if (ready2) a2 = 1;
      @(negedge clk);
    end
    valid = 1'b0;
    check("push_accept", {30'd0, a0, a2}, 32'd3);
    hold_m.push_back(w);
  endtask

  // One CS-low frame with nbits DCLK pulses; nbits < W ends in an abort.
  task automatic run_frame(input int nbits, input int half);
    logic [W-1:0] exp;
    logic [W-1:0] rx0 = '0;
    logic [W-1:0] rx2 = '0;
    bit exp_under;
    int bd0 = n_done0, ba0 = n_abort0, bu0 = n_under0;
    int bd2 = n_done2, ba2 = n_abort2, bu2 = n_under2;
    bit full = (nbits == W);

    cs = 1'b0;
    if (hold_m.size() > 0) begin
      exp         = hold_m.pop_front();
      exp_under   = 0;
      last_word_m = exp;
    end else begin
      exp_under = 1;
`ifdef ADC_SPI_RESP_UNDERRUN_EN
      exp = UNDER;
`else
      exp = last_word_m;
`endif
    end

    // MSB after 1 cycle direct, after 3 cycles through two sync stages.
    @(negedge clk);
    check("msb_lat_direct", {31'd0, data0}, {31'd0, exp[W-1]});
    check("msb_lat_sync_c1", {31'd0, data2}, 32'd0);
    @(negedge clk);
    check("msb_lat_sync_c2", {31'd0, data2}, 32'd0);
    @(negedge clk);
    check("msb_lat_sync_c3", {31'd0, data2}, {31'd0, exp[W-1]});
    repeat (half - 3) @(negedge clk);

    for (int i = 0; i < nbits; i++) begin
      rx0  = {rx0[W-2:0], data0};
      rx2  = {rx2[W-2:0], data2};
      dclk = 1'b1;
      repeat (half) @(negedge clk);
      dclk = 1'b0;
      repeat (half) @(negedge clk);
    end
    cs = 1'b1;
    repeat (8) @(negedge clk);

    check("rx_word_direct", {16'd0, rx0}, {16'd0, exp >> (W - nbits)});
    check("rx_word_sync", {16'd0, rx2}, {16'd0, exp >> (W - nbits)});
    check("done_direct", n_done0 - bd0, full ? 1 : 0);
    check("done_sync", n_done2 - bd2, full ? 1 : 0);
    check("abort_direct", n_abort0 - ba0, full ? 0 : 1);
    check("abort_sync", n_abort2 - ba2, full ? 0 : 1);
    check("underrun_direct", n_under0 - bu0, {31'd0, exp_under});
    check("underrun_sync", n_under2 - bu2, {31'd0, exp_under});
    check("idle_data", {30'd0, data0, data2}, 32'd0);
    check("ready_direct", {31'd0, ready0}, {31'd0, hold_m.size() == 0});
    check("ready_sync", {31'd0, ready2}, {31'd0, hold_m.size() == 0});
  endtask

  initial begin
    rst    = 1'b1;
    cs     = 1'b1;
    dclk   = 1'b0;
    valid  = 1'b0;
    sample = '0;
    repeat (3) @(negedge clk);
    check("rst_ready", {30'd0, ready0, ready2}, 32'd3);
    check("rst_data", {30'd0, data0, data2}, 32'd0);
    check("rst_pulses", {26'd0, done0, abort0, under0, done2, abort2, under2}, 32'd0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // Underrun straight after reset.
    run_frame(W, 5);

    // Basic frame.
    push(16'hA5C3);
    check("ready_low_when_full", {30'd0, ready0, ready2}, 32'd0);
    run_frame(W, 4);

    // Backpressure: 2222 waits for the 1111 frame's CS fall.
    push(16'h1111);
    repeat (5) @(negedge clk);
    check("bp_ready_low", {30'd0, ready0, ready2}, 32'd0);
    fork
      push(16'h2222);
      run_frame(W, 6);
    join
    run_frame(W, 5);

    // Synchronized-mode timing word.
    push(16'h8001);
    run_frame(W, 6);

    // Abort after 7 rises, then a clean frame of the next word.
    push(16'hC0DE);
    run_frame(7, 4);
    push(16'h9ABC);
    run_frame(W, 4);

    // Async reset after bit 4 of a frame.
    push(16'hF00F);
    cs = 1'b0;
    void'(hold_m.pop_front());
    repeat (6) @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      dclk = 1'b1;
      repeat (5) @(negedge clk);
      dclk = 1'b0;
      repeat (5) @(negedge clk);
    end
    push(16'h5A5A);
    rst = 1'b1;
    #1;
    check("midrst_data", {30'd0, data0, data2}, 32'd0);
    check("midrst_ready", {30'd0, ready0, ready2}, 32'd3);
    check("midrst_pulses", {26'd0, done0, abort0, under0, done2, abort2, under2}, 32'd0);
    cs = 1'b1;
    hold_m.delete();
    last_word_m = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    push(16'h3C96);
    run_frame(W, 5);

    // Randomized frames.
    for (int k = 0; k < 24; k++) begin
      int half = $urandom_range(7, 4);
      int nb   = ($urandom_range(4) == 0) ? $urandom_range(W - 1, 1) : W;
      if (hold_m.size() == 0 && $urandom_range(3) != 0) begin
        push(W'($urandom));
      end
      if (hold_m.size() == 1 && $urandom_range(1) == 0) begin
        fork
          push(W'($urandom));
          run_frame(nb, half);
        join
      end else begin
        run_frame(nb, half);
      end
      repeat ($urandom_range(3)) @(negedge clk);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
